// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Widest one-hot vector oht2bin accepts; callers zero-extend into it.
  localparam int unsigned OHT_MAX_W = 1024;
  localparam int unsigned OHT_BIN_W = 32;

  // One-hot to binary: ORs the indices of all set bits (exact for one-hot or zero).
  function automatic logic [OHT_BIN_W-1:0] oht2bin(input logic [OHT_MAX_W-1:0] oh);
    logic [OHT_BIN_W-1:0] bin;
    bin = '0;
    for (int unsigned i = 0; i < OHT_MAX_W; i++) begin
      if (oh[i]) bin = bin | OHT_BIN_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/arb_rr_base_pry2oht.sv
// Rightmost-priority picker: keeps only the lowest set bit of req.
module pry2oht_base
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  if (IMPLEMENTATION == 0) begin : g_adder
    // Two's complement isolates the lowest set bit.
    assign gnt = req & (~req + WIDTH'(1));
  end else if (IMPLEMENTATION == 1) begin : g_loop
    logic found;
    // First set bit from the bottom wins.
    always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (req[i] && !found) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end else if (IMPLEMENTATION == 2) begin : g_vector
    logic [WIDTH-1:0] below;
    // Prefix-OR of lower bits masks off every set bit except the lowest.
    always_comb begin
      below = '0;
      for (int unsigned i = 1; i < WIDTH; i++) begin
        below[i] = below[i-1] | req[i-1];
      end
      gnt = req & ~below;
    end
  end else begin : g_bad
    $fatal(1, "pry2oht_base: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
    assign gnt = '0;
  end

endmodule

// File: rtl/arb_rr_base.sv
// Round-robin arbiter with registered, held-until-accepted valid/ready grant.
module arb_rr_base
  import arb_pkg::*;
#(
  parameter  int unsigned WIDTH          = 32,
  parameter  int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  output logic                 vld,
  input  logic                 rdy,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] idx
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "arb_rr_base: WIDTH must be >= 2");
  end

  arb_state_t           state_q, state_d;
  logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]     gnt_d;
  logic [WIDTH_LOG-1:0] idx_d;
  logic                 vld_d;

  logic                 xfer;
  logic [WIDTH-1:0]     req_eff;
  logic [WIDTH_LOG-1:0] ptr_eff;
  logic [WIDTH-1:0]     msk;
  logic [WIDTH-1:0]     req_m;
  logic [WIDTH-1:0]     pick_m, pick_u, pick;
  logic                 any;
  logic [WIDTH_LOG-1:0] pick_idx;

  // Search inputs: on a transfer the served bit is dropped and the search starts above it.
  always_comb begin
    xfer    = (state_q == BUSY) && rdy;
    req_eff = xfer ? (req & ~gnt) : req;
    ptr_eff = xfer ? idx : ptr_q;
    msk     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      msk[i] = (WIDTH_LOG'(i) > ptr_eff);
    end
    req_m = req_eff & msk;
  end

  pry2oht_base #(.WIDTH(WIDTH), .IMPLEMENTATION(IMPLEMENTATION)) u_pick_m (
    .req (req_m),
    .gnt (pick_m)
  );

  pry2oht_base #(.WIDTH(WIDTH), .IMPLEMENTATION(IMPLEMENTATION)) u_pick_u (
    .req (req_eff),
    .gnt (pick_u)
  );

  // Masked pick first, wrap to the unmasked pick when nothing lies above the pointer.
  always_comb begin
    pick     = (|req_m) ? pick_m : pick_u;
    any      = |req_eff;
    pick_idx = WIDTH_LOG'(oht2bin(OHT_MAX_W'(pick)));
  end

  // Next-state, next-grant and pointer update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    idx_d   = idx;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = BUSY;
          gnt_d   = pick;
          idx_d   = pick_idx;
        end
      end
      BUSY: begin
        if (rdy) begin
          ptr_d = idx;
          if (any) begin
            gnt_d = pick;
            idx_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    vld_d = (state_d == BUSY);
  end

  // State, grant and pointer registers; pointer resets to the top so bit 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= WIDTH_LOG'(WIDTH - 1);
      gnt     <= '0;
      idx     <= '0;
      vld     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      idx     <= idx_d;
      vld     <= vld_d;
    end
  end

endmodule

// File: tb/tb_arb_rr_base.sv
// Bench for arb_rr_base: three pick implementations run in lockstep against one scoreboard.
module tb_arb_rr_base;

  localparam int unsigned W  = 4;
  localparam int unsigned WL = 2;
  localparam int          ND = 3;

  typedef logic [W+WL:0] obs_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  req   = '0;
  logic          rdy   = 1'b0;
  logic          vld_o [ND];
  logic [W-1:0]  gnt_o [ND];
  logic [WL-1:0] idx_o [ND];

  obs_t exp_q [$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state
  bit   m_vld;
  int   m_idx;
  int   m_ptr;

  always #5 clk = ~clk;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    arb_rr_base #(.WIDTH(W), .IMPLEMENTATION(k)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .vld   (vld_o[k]),
      .rdy   (rdy),
      .gnt   (gnt_o[k]),
      .idx   (idx_o[k])
    );
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [W-1:0] g);
    logic [WL-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) if (g[i]) b = WL'(i);
    return {(g != '0), g, b};
  endfunction

  function automatic int next_from(input int start, input logic [W-1:0] r);
    for (int k = 1; k <= W; k++) begin
      int j;
      j = (start + k) % W;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic push(input logic [W-1:0] g);
    exp_q.push_back(mk(g));
  endtask

  task automatic check_now(input string tag);
    obs_t e, got;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < ND; k++) begin
      got = {vld_o[k], gnt_o[k], idx_o[k]};
      checks++;
      assert (got === e) passed++;
      else $error("FAIL %s impl%0d: got vld/gnt/idx=%b required %b", tag, k, got, e);
    end
  endtask

  task automatic step(input logic [W-1:0] r, input logic y, input logic [W-1:0] g, input string tag);
    req = r;
    rdy = y;
    push(g);
    @(posedge clk);
    #1;
    check_now(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rdy   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic y, output logic [W-1:0] g);
    int n;
    if (!m_vld) begin
      n = next_from(m_ptr, r);
      if (n >= 0) begin
        m_vld = 1'b1;
        m_idx = n;
      end
    end else if (y) begin
      m_ptr = m_idx;
      n = next_from(m_idx, r & ~(W'(1) << m_idx));
      if (n >= 0) m_idx = n;
      else        m_vld = 1'b0;
    end
    g = m_vld ? (W'(1) << m_idx) : '0;
  endtask

  initial begin
    logic [W-1:0] pending, r, g;
    logic         y;
    int           wait_cnt [W];
    int           s;

    // Async reset with all requests up
    rst_n = 1'b0;
    req   = 4'hF;
    rdy   = 1'b1;
    #2;
    push('0);
    check_now("rst_async");
    repeat (2) @(posedge clk);
    #1;
    push('0);
    check_now("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Full rotation with all requesters held
    step(4'hF, 1'b1, 4'b0001, "rr0");
    step(4'hF, 1'b1, 4'b0010, "rr1");
    step(4'hF, 1'b1, 4'b0100, "rr2");
    step(4'hF, 1'b1, 4'b1000, "rr3");
    step(4'hF, 1'b1, 4'b0001, "rr4");
    do_reset();

    // Grant held while rdy is low, then advances past the served bit
    step(4'b0101, 1'b0, 4'b0001, "hold_pick");
    step(4'b0101, 1'b0, 4'b0001, "hold1");
    step(4'b0101, 1'b0, 4'b0001, "hold2");
    step(4'b0101, 1'b0, 4'b0001, "hold3");
    step(4'b0101, 1'b1, 4'b0100, "after_hold");
    step(4'b0100, 1'b0, 4'b0100, "busy_hold");

    // Reset mid-BUSY drops outputs without a clock; restart from bit 0
    rst_n = 1'b0;
    #1;
    push('0);
    check_now("rst_mid_busy");
    @(negedge clk);
    req   = 4'b0110;
    rst_n = 1'b1;
    step(4'b0110, 1'b0, 4'b0010, "post_rst");
    do_reset();

    // Pointer at 3 wraps to bit 0, then moves on to bit 3
    step(4'b1000, 1'b1, 4'b1000, "wrap_a");
    step(4'b1000, 1'b1, 4'b0000, "wrap_idle");
    step(4'b1001, 1'b0, 4'b0001, "wrap_pick");
    step(4'b1001, 1'b1, 4'b1000, "wrap_next");
    step(4'b1000, 1'b1, 4'b0000, "wrap_done");
    do_reset();

    // Lone requester alternates grant / idle
    step(4'b0001, 1'b1, 4'b0001, "single0");
    step(4'b0001, 1'b1, 4'b0000, "single1");
    step(4'b0001, 1'b1, 4'b0001, "single2");
    step(4'b0001, 1'b1, 4'b0000, "single3");
    do_reset();

    // Random traffic against the reference model, with a starvation bound
    m_vld   = 1'b0;
    m_idx   = 0;
    m_ptr   = W - 1;
    pending = '0;
    for (int i = 0; i < W; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      r = pending | (W'($urandom) & W'($urandom));
      y = ($urandom_range(0, 3) != 0);
      req = r;
      rdy = y;
      if (vld_o[0] && y) begin
        s = int'(idx_o[0]);
        checks++;
        assert (wait_cnt[s] <= W - 1) passed++;
        else $error("FAIL starve req%0d: waited %0d grants, bound %0d", s, wait_cnt[s], W - 1);
        for (int i = 0; i < W; i++) begin
          if (r[i] && i != s) wait_cnt[i]++;
        end
        wait_cnt[s] = 0;
        pending = r & ~(W'(1) << s);
      end else begin
        pending = r;
      end
      for (int i = 0; i < W; i++) if (!r[i]) wait_cnt[i] = 0;
      model_step(r, y, g);
      push(g);
      @(posedge clk);
      #1;
      check_now("rand");
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
